// File: rtl/ula_pkg.sv
// Shared constants and types for the 8-bit ALU controller and its multiply datapath.
package ula_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned FLAG_W   = 3;
    localparam int unsigned MUL_ITER = 8;
    localparam int unsigned CNT_W    = 4;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR = 3'b010;
    localparam logic [OP_W-1:0] OP_NOT = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB = 3'b101;
    localparam logic [OP_W-1:0] OP_MUL = 3'b110;
    localparam logic [OP_W-1:0] OP_CLR = 3'b111;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_MUL  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic [FLAG_W-1:0] flags;
    } res_t;

endpackage

// File: rtl/controlador_ula_8bits_if.sv
// Command and result valid/ready channels of the ALU controller.
interface controlador_ula_8bits_if;
    import ula_pkg::*;

    logic              cmd_valid_in;
    logic              cmd_ready_out;
    logic [OP_W-1:0]   cmd_op_in;
    logic [DATA_W-1:0] cmd_a_in;
    logic [DATA_W-1:0] cmd_b_in;
    logic              cmd_c_in;
    logic              cmd_usa_acc_in;
    logic              cmd_usa_carry_in;

    logic              res_valid_out;
    logic              res_ready_in;
    logic [DATA_W-1:0] res_out;
    logic [DATA_W-1:0] res_hi_out;
    logic [FLAG_W-1:0] flags_out;

    modport master (
        output cmd_valid_in, cmd_op_in, cmd_a_in, cmd_b_in, cmd_c_in,
               cmd_usa_acc_in, cmd_usa_carry_in, res_ready_in,
        input  cmd_ready_out, res_valid_out, res_out, res_hi_out, flags_out
    );

    modport slave (
        input  cmd_valid_in, cmd_op_in, cmd_a_in, cmd_b_in, cmd_c_in,
               cmd_usa_acc_in, cmd_usa_carry_in, res_ready_in,
        output cmd_ready_out, res_valid_out, res_out, res_hi_out, flags_out
    );

endinterface

// File: rtl/multiplicador_seq_8bits.sv
// Shift-add multiply state: partial product high byte, multiplier shift register, iteration counter.
module multiplicador_seq_8bits
    import ula_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] mcand,
    input  logic [DATA_W-1:0] mult,
    input  logic [DATA_W-1:0] sum,
    input  logic              cout,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] addend,
    output logic [DATA_W-1:0] hi_next_c,
    output logic [DATA_W-1:0] lo_next_c,
    output logic              last_c
);

    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-2:0] lo_upper;
    logic [CNT_W-1:0]  cnt;

    // Bit 0 of the multiplier is consumed as soon as it is loaded, so only the upper bits are kept.
    always_comb begin
        hi_next_c = {cout, sum[DATA_W-1:1]};
        lo_next_c = {sum[0], lo_upper};
        last_c    = (cnt == CNT_W'(MUL_ITER - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            hi       <= '0;
            lo_upper <= '0;
            addend   <= '0;
            cnt      <= '0;
        end else if (start) begin
            mcand_q  <= mcand;
            hi       <= '0;
            lo_upper <= mult[DATA_W-1:1];
            addend   <= mult[0] ? mcand : '0;
            cnt      <= '0;
        end else if (step) begin
            hi       <= hi_next_c;
            lo_upper <= lo_next_c[DATA_W-1:1];
            addend   <= lo_next_c[0] ? mcand_q : '0;
            cnt      <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/controlador_ula_8bits.sv
// Sequencer sharing one external combinational ALU behind valid/ready command and result channels.
module controlador_ula_8bits
    import ula_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    controlador_ula_8bits_if.slave  bus,
    output logic [DATA_W-1:0]       acc_out,
    output logic                    ocupado_out,
    output logic [DATA_W-1:0]       alu_a_out,
    output logic [DATA_W-1:0]       alu_b_out,
    output logic                    alu_c_out,
    output logic [OP_W-1:0]         alu_op_out,
    input  logic [DATA_W-1:0]       alu_saida_in,
    input  logic [FLAG_W-1:0]       alu_flags_in
);

    state_t            state, state_next;
    logic              accept_c, mul_start_c, mul_step_c, mul_last_c;
    logic [DATA_W-1:0] a_sel_c, mul_hi, mul_addend, hi_next_c, lo_next_c;
    logic              c_sel_c, carry_q, alu_c_q;
    logic [OP_W-1:0]   op_q, alu_op_q;
    logic [DATA_W-1:0] a_q, b_q, acc_q;
    logic [FLAG_W-1:0] mul_flags_c;
    res_t              res_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= ST_IDLE;
            bus.cmd_ready_out <= 1'b0;
            bus.res_valid_out <= 1'b0;
            ocupado_out       <= 1'b0;
        end else begin
            state             <= state_next;
            bus.cmd_ready_out <= (state_next == ST_IDLE);
            bus.res_valid_out <= (state_next == ST_DONE);
            ocupado_out       <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        state_next  = state;
        accept_c    = 1'b0;
        mul_start_c = 1'b0;
        mul_step_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid_in && bus.cmd_ready_out) begin
                    accept_c = 1'b1;
                    if (bus.cmd_op_in == OP_CLR) begin
                        state_next = ST_DONE;
                    end else if (bus.cmd_op_in == OP_MUL) begin
                        state_next  = ST_MUL;
                        mul_start_c = 1'b1;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: state_next = ST_DONE;
            ST_MUL: begin
                mul_step_c = 1'b1;
                if (mul_last_c) state_next = ST_DONE;
            end
            ST_DONE: if (bus.res_ready_in) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand selection and ALU drive; MUL borrows the ALU adder for its partial sums.
    always_comb begin
        a_sel_c                  = bus.cmd_usa_acc_in ? acc_q : bus.cmd_a_in;
        c_sel_c                  = bus.cmd_usa_carry_in ? carry_q : bus.cmd_c_in;
        mul_flags_c              = '0;
        mul_flags_c[FLAG_ZERO]   = ({hi_next_c, lo_next_c} == '0);
        alu_a_out                = (state == ST_MUL) ? mul_hi : a_q;
        alu_b_out                = (state == ST_MUL) ? mul_addend : b_q;
        alu_c_out                = alu_c_q;
        alu_op_out               = alu_op_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_c_q  <= 1'b0;
            alu_op_q <= OP_AND;
            res_q    <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
        end else if (accept_c) begin
            op_q    <= bus.cmd_op_in;
            a_q     <= a_sel_c;
            b_q     <= bus.cmd_b_in;
            alu_c_q <= (bus.cmd_op_in == OP_MUL) ? 1'b0 : c_sel_c;
            if (bus.cmd_op_in == OP_MUL)      alu_op_q <= OP_ADD;
            else if (bus.cmd_op_in == OP_CLR) alu_op_q <= OP_AND;
            else                              alu_op_q <= bus.cmd_op_in;
            if (bus.cmd_op_in == OP_CLR) begin
                res_q   <= '0;
                acc_q   <= '0;
                carry_q <= 1'b0;
            end
        end else if (state == ST_EXEC) begin
            res_q    <= '{hi: '0, lo: alu_saida_in, flags: alu_flags_in};
            acc_q    <= alu_saida_in;
            alu_op_q <= OP_AND;
            if (op_q == OP_ADD || op_q == OP_SUB) carry_q <= alu_flags_in[FLAG_CARRY];
        end else if (mul_step_c && mul_last_c) begin
            res_q    <= '{hi: hi_next_c, lo: lo_next_c, flags: mul_flags_c};
            acc_q    <= lo_next_c;
            alu_op_q <= OP_AND;
        end
    end

    assign bus.res_out    = res_q.lo;
    assign bus.res_hi_out = res_q.hi;
    assign bus.flags_out  = res_q.flags;
    assign acc_out        = acc_q;

    multiplicador_seq_8bits u_mul (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .start     (mul_start_c),
        .step      (mul_step_c),
        .mcand     (a_sel_c),
        .mult      (bus.cmd_b_in),
        .sum       (alu_saida_in),
        .cout      (alu_flags_in[FLAG_CARRY]),
        .hi        (mul_hi),
        .addend    (mul_addend),
        .hi_next_c (hi_next_c),
        .lo_next_c (lo_next_c),
        .last_c    (mul_last_c)
    );

endmodule

// File: tb/tb_controlador_ula_8bits.sv
// Bench for controlador_ula_8bits: models the external ALU and checks results against an arithmetic reference.
module tb_controlador_ula_8bits;
    import ula_pkg::*;

    logic       clk_in   = 1'b0;
    logic       rst_n_in = 1'b1;
    logic [7:0] acc_out, alu_a_out, alu_b_out, alu_saida_in;
    logic       ocupado_out, alu_c_out;
    logic [2:0] alu_op_out, alu_flags_in;
    logic [49:0] all_out;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] m_acc   = 8'h00;
    logic       m_carry = 1'b0;

    controlador_ula_8bits_if bus();

    controlador_ula_8bits dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .bus          (bus),
        .acc_out      (acc_out),
        .ocupado_out  (ocupado_out),
        .alu_a_out    (alu_a_out),
        .alu_b_out    (alu_b_out),
        .alu_c_out    (alu_c_out),
        .alu_op_out   (alu_op_out),
        .alu_saida_in (alu_saida_in),
        .alu_flags_in (alu_flags_in)
    );

    always #5 clk_in = ~clk_in;

    assign all_out = {bus.cmd_ready_out, bus.res_valid_out, bus.res_out, bus.res_hi_out, bus.flags_out,
                      acc_out, ocupado_out, alu_a_out, alu_b_out, alu_c_out, alu_op_out};

    // External ULA_8Bits: {flags(ovf,carry,zero), result}
    function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                           input logic c);
        logic [8:0] w;
        logic [7:0] r;
        logic       cy, ov;
        w = '0; r = '0; cy = 1'b0; ov = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_ADD: begin
                w = {1'b0, a} + {1'b0, b} + {8'h00, c};
                r = w[7:0]; cy = w[8]; ov = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                w = {1'b0, a} - {1'b0, b} - {8'h00, c};
                r = w[7:0]; cy = w[8]; ov = (a[7] != b[7]) && (r[7] != a[7]);
            end
            default: r = 8'h00;
        endcase
        return {ov, cy, (r == 8'h00), r};
    endfunction

    always_comb {alu_flags_in, alu_saida_in} = alu_fn(alu_op_out, alu_a_out, alu_b_out, alu_c_out);

    function automatic res_t model_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                       input logic c);
        logic [15:0] p;
        logic [10:0] f;
        if (op == OP_MUL) begin
            p = 16'(a) * 16'(b);
            return '{hi: p[15:8], lo: p[7:0], flags: {2'b00, (p == 16'h0000)}};
        end
        if (op == OP_CLR) return '0;
        f = alu_fn(op, a, b, c);
        return '{hi: 8'h00, lo: f[7:0], flags: f[10:8]};
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        if (op == OP_CLR) return 1;
        if (op == OP_MUL) return 9;
        return 2;
    endfunction

    task automatic model_update(input logic [2:0] op, input res_t r);
        m_acc = r.lo;
        if (op == OP_ADD || op == OP_SUB) m_carry = r.flags[FLAG_CARRY];
        if (op == OP_CLR) m_carry = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic ua, input logic uc);
        int n;
        bus.cmd_op_in = op; bus.cmd_a_in = a; bus.cmd_b_in = b; bus.cmd_c_in = c;
        bus.cmd_usa_acc_in = ua; bus.cmd_usa_carry_in = uc; bus.cmd_valid_in = 1'b1;
        n = 0;
        while (bus.cmd_ready_out !== 1'b1 && n < 20) begin @(negedge clk_in); n++; end
        if (bus.cmd_ready_out !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_cmd: cmd_ready_out=%b after %0d cycles, required 1", bus.cmd_ready_out, n);
        end
        @(posedge clk_in);
        @(negedge clk_in);
        bus.cmd_valid_in = 1'b0;
        bus.cmd_op_in = 3'($urandom); bus.cmd_a_in = 8'($urandom); bus.cmd_b_in = 8'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (bus.res_valid_out !== 1'b1 && lat < 30) begin @(negedge clk_in); lat++; end
        if (bus.res_valid_out !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_result: res_valid_out=%b after %0d cycles, required 1", bus.res_valid_out, lat);
        end
    endtask

    task automatic exec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic ua, input logic uc, output int lat, output res_t obs);
        send_cmd(op, a, b, c, ua, uc);
        wait_result(lat);
        obs = '{hi: bus.res_hi_out, lo: bus.res_out, flags: bus.flags_out};
    endtask

    task automatic take_result();
        bus.res_ready_in = 1'b1;
        @(negedge clk_in);
        bus.res_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid_in = 1'b0; bus.res_ready_in = 1'b0; bus.cmd_op_in = '0; bus.cmd_a_in = '0;
        bus.cmd_b_in = '0; bus.cmd_c_in = 1'b0; bus.cmd_usa_acc_in = 1'b0; bus.cmd_usa_carry_in = 1'b0;
        #1 rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", all_out); end
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (bus.cmd_ready_out !== 1'b1 || ocupado_out !== 1'b0) begin
            errors++; $display("FAIL reset_release: cmd_ready=%b ocupado=%b, required 1/0", bus.cmd_ready_out, ocupado_out);
        end
        m_acc = 8'h00; m_carry = 1'b0;
    endtask

    task automatic test_add_ovf();
        int lat; res_t obs;
        exec(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, lat, obs);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_lat: got %0d, required 2", lat); end
        checks++; if (obs.lo !== 8'h80) begin errors++; $display("FAIL add_res: got %h, required 80", obs.lo); end
        checks++; if (obs.flags !== 3'b100) begin errors++; $display("FAIL add_flags: got %b, required 100", obs.flags); end
        checks++; if (obs.hi !== 8'h00) begin errors++; $display("FAIL add_hi: got %h, required 00", obs.hi); end
        checks++; if (acc_out !== 8'h80) begin errors++; $display("FAIL add_acc: got %h, required 80", acc_out); end
        take_result();
        m_acc = 8'h80; m_carry = 1'b0;
    endtask

    task automatic test_mul();
        int lat; res_t obs;
        exec(OP_MUL, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, lat, obs);
        checks++; if (lat !== 9) begin errors++; $display("FAIL mul_lat: got %0d, required 9", lat); end
        checks++; if ({obs.hi, obs.lo} !== 16'hFE01) begin errors++; $display("FAIL mul_ff: got %h%h, required FE01", obs.hi, obs.lo); end
        checks++; if (obs.flags !== 3'b000) begin errors++; $display("FAIL mul_ff_flags: got %b, required 000", obs.flags); end
        checks++; if (acc_out !== 8'h01) begin errors++; $display("FAIL mul_acc: got %h, required 01", acc_out); end
        take_result();
        exec(OP_MUL, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, lat, obs);
        checks++; if ({obs.hi, obs.lo} !== 16'h0000) begin errors++; $display("FAIL mul_zero: got %h%h, required 0000", obs.hi, obs.lo); end
        checks++; if (obs.flags !== 3'b001) begin errors++; $display("FAIL mul_zero_flags: got %b, required 001", obs.flags); end
        take_result();
        m_acc = 8'h00;
    endtask

    task automatic test_chain();
        int lat; res_t obs;
        exec(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat, obs);
        checks++; if (obs.flags !== 3'b011) begin errors++; $display("FAIL chain_carry: got %b, required 011", obs.flags); end
        take_result();
        exec(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, lat, obs);
        checks++; if (obs.lo !== 8'h01) begin errors++; $display("FAIL chain_add: got %h, required 01", obs.lo); end
        take_result();
        exec(OP_XOR, 8'hA5, 8'h01, 1'b0, 1'b1, 1'b0, lat, obs);
        checks++; if (obs.lo !== 8'h00) begin errors++; $display("FAIL chain_xor: got %h, required 00", obs.lo); end
        take_result();
        m_acc = 8'h00; m_carry = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat; res_t obs, exp;
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        exp = model_res(OP_OR, a, b, 1'b0);
        exec(OP_OR, a, b, 1'b0, 1'b0, 1'b0, lat, obs);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.res_valid_out !== 1'b1 || bus.cmd_ready_out !== 1'b0 ||
                {bus.res_hi_out, bus.res_out, bus.flags_out} !== exp) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b res=%h%h flags=%b, required 1/0 %h", i,
                         bus.res_valid_out, bus.cmd_ready_out, bus.res_hi_out, bus.res_out, bus.flags_out, exp);
            end
            bus.cmd_valid_in = 1'b1; bus.cmd_op_in = OP_CLR;
            @(negedge clk_in);
        end
        bus.cmd_valid_in = 1'b0;
        take_result();
        checks++;
        if (bus.cmd_ready_out !== 1'b1 || acc_out !== exp.lo) begin
            errors++; $display("FAIL bp_release: cmd_ready=%b acc=%h, required 1 %h", bus.cmd_ready_out, acc_out, exp.lo);
        end
        model_update(OP_OR, exp);
    endtask

    task automatic test_clr();
        int lat; res_t obs;
        exec(OP_ADD, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0, lat, obs);
        take_result();
        exec(OP_CLR, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0, lat, obs);
        checks++; if (lat !== 1) begin errors++; $display("FAIL clr_lat: got %0d, required 1", lat); end
        checks++;
        if (obs !== '0 || acc_out !== 8'h00) begin
            errors++; $display("FAIL clr_res: got %h acc=%h, required 0 00", obs, acc_out);
        end
        take_result();
        exec(OP_ADD, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, lat, obs);
        checks++; if (obs.lo !== 8'h00) begin errors++; $display("FAIL clr_carry: got %h, required 00", obs.lo); end
        take_result();
        m_acc = 8'h00; m_carry = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int lat; res_t obs;
        logic [7:0] b;
        exec(OP_ADD, 8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, lat, obs);
        take_result();
        send_cmd(OP_MUL, 8'h9D, 8'h7B, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk_in);
        checks++; if (ocupado_out !== 1'b1) begin errors++; $display("FAIL mid_mul_busy: got %b, required 1", ocupado_out); end
        rst_n_in = 1'b0;
        #1;
        checks++; if (all_out !== '0) begin errors++; $display("FAIL mid_mul_reset: got %h, required 0", all_out); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checks++; if (bus.res_valid_out !== 1'b0) begin errors++; $display("FAIL mid_mul_novalid%0d: got %b, required 0", i, bus.res_valid_out); end
        end
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checks++; if (bus.cmd_ready_out !== 1'b1) begin errors++; $display("FAIL mid_mul_ready: got %b, required 1", bus.cmd_ready_out); end
        m_acc = 8'h00; m_carry = 1'b0;
        b = 8'($urandom_range(1, 255));
        exec(OP_ADD, 8'hEE, b, 1'b1, 1'b1, 1'b1, lat, obs);
        checks++;
        if (lat !== 2 || obs.lo !== b || acc_out !== b) begin
            errors++; $display("FAIL post_reset_add: lat=%0d res=%h acc=%h, required 2 %h %h", lat, obs.lo, acc_out, b, b);
        end
        take_result();
        m_acc = b;
    endtask

    task automatic test_random();
        int lat; res_t obs, exp;
        logic [2:0] op; logic [7:0] a, b, a_eff; logic c, ua, uc, c_eff;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
            c = 1'($urandom); ua = 1'($urandom); uc = 1'($urandom);
            a_eff = ua ? m_acc : a;
            c_eff = uc ? m_carry : c;
            exp = model_res(op, a_eff, b, c_eff);
            exec(op, a, b, c, ua, uc, lat, obs);
            checks++; if (lat !== exp_lat(op)) begin errors++; $display("FAIL rnd%0d_lat op=%0d: got %0d, required %0d", i, op, lat, exp_lat(op)); end
            checks++; if (obs !== exp) begin errors++; $display("FAIL rnd%0d_res op=%0d a=%h b=%h c=%b: got %h, required %h", i, op, a_eff, b, c_eff, obs, exp); end
            checks++; if (acc_out !== exp.lo) begin errors++; $display("FAIL rnd%0d_acc: got %h, required %h", i, acc_out, exp.lo); end
            take_result();
            model_update(op, exp);
        end
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_mul();
        test_chain();
        test_backpressure();
        test_clr();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/controlador_ula_8bits.md
Name: controlador_ula_8bits

Overview:
Sequencer that owns one ULA_8Bits instance (wired externally) and shares it behind a valid/ready command interface. It executes single-cycle ALU operations and a multi-cycle 8x8 shift-add multiply that reuses the ALU adder. It keeps an accumulator and a carry register so multi-byte arithmetic can be chained. Results are returned over a valid/ready result interface with backpressure.

Parameters:
MUL_ITER, 8, number of shift-add iterations for MUL; fixed at the operand width.

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  asynchronous active-low reset
cmd_valid_in  in  1  command present
cmd_ready_out  out  1  controller can accept a command
cmd_op_in  in  3  000 AND, 001 OR, 010 XOR, 011 NOT, 100 ADD, 101 SUB, 110 MUL, 111 CLR
cmd_a_in  in  8  operand A
cmd_b_in  in  8  operand B
cmd_c_in  in  1  explicit carry/borrow-in
cmd_usa_acc_in  in  1  1: A operand is the accumulator instead of cmd_a_in
cmd_usa_carry_in  in  1  1: carry-in is the carry register instead of cmd_c_in
res_valid_out  out  1  result available
res_ready_in  in  1  consumer takes the result
res_out  out  8  result, or product low byte for MUL
res_hi_out  out  8  product high byte for MUL; 0 otherwise
flags_out  out  3  latched flags
acc_out  out  8  accumulator
ocupado_out  out  1  high in any state other than IDLE
alu_a_out, alu_b_out  out  8  to ALU A_in/B_in
alu_c_out  out  1  to ALU C_in
alu_op_out  out  3  to ALU Operacao_in
alu_saida_in  in  8  from ALU Saida_out
alu_flags_in  in  3  from ALU Flags_out

Behaviour:
- Reset, asynchronous: state IDLE. All registers and outputs are 0. cmd_ready_out asserts when reset deasserts.
- States:
  - IDLE: cmd_ready_out=1. A handshake (valid&ready) at edge T captures op, A (acc or cmd_a_in), B, and C (carry_reg or cmd_c_in).
  - From IDLE, op 000–101 goes to EXEC, 110 goes to MUL, 111 goes to DONE.
  - EXEC, one cycle: ALU is driven from captured registers. At the end of the cycle, latch res=alu_saida_in and flags=alu_flags_in, then go to DONE.
  - MUL: initialise hi=0, lo=B at acceptance, with counter=0. Each cycle: alu_op=100, alu_a=hi, alu_b=(lo[0]?A:0), alu_c=0. At the edge, hi<={alu_flags_in[FLAG_CARRY], alu_saida_in[7:1]}, lo<={alu_saida_in[0], lo[7:1]}, and counter increments. After MUL_ITER cycles go to DONE.
  - MUL flags are 000 except flags[FLAG_ZERO]=1 when the 16-bit product is 0.
  - CLR: res=0, flags=000, acc=0, carry_reg=0.
  - DONE: res_valid_out=1, outputs held stable. On res_ready_in go to IDLE; no command is accepted in the same cycle.
- Latency: single op has res_valid_out at T+2. MUL has res_valid_out at T+MUL_ITER+1 (T+9). CLR has res_valid_out at T+1.
- On leaving EXEC, MUL or CLR: acc<=result low byte. carry_reg<=alu_flags_in[FLAG_CARRY] only for ADD/SUB; otherwise unchanged (CLR clears it).
- ALU drive in IDLE/DONE: op=000, operand registers unchanged. The ALU is purely combinational; its result is sampled in the same cycle it is driven.
- Ops 011 (NOT) ignores B. res_hi_out=0 for every op other than MUL.
- cmd_*_in are ignored when cmd_ready_out=0. Result registers must not change while res_valid_out=1 and res_ready_in=0.
- Reset asserted in any state, including mid-MUL, aborts the operation immediately. No result is produced and acc/carry_reg return to 0.

Decomposition:
- Package ula_pkg holds:
  - op code constants OP_AND..OP_CLR;
  - flag indices FLAG_ZERO=0, FLAG_CARRY=1, FLAG_OVF=2;
  - state enum {IDLE, EXEC, MUL, DONE}.
- One sub-module, multiplicador_seq_8bits (hi/lo/counter shift-add datapath). FSM and handshakes stay in the top.

Test Plan:
- ADD A=0x7F, B=0x01, cin=0 accepted at T -> res_valid_out at T+2, res_out=0x80, flags[FLAG_OVF]=1, acc_out=0x80.
- MUL A=0xFF, B=0xFF -> res_valid_out exactly at T+9, res_hi_out=0xFE, res_out=0x01. Also MUL 0x00*0x5A -> 0x0000 with flags[FLAG_ZERO]=1.
- Chained add: ADD 0xFF+0x01 (carry_reg=1), then ADD A=0x00, B=0x00, usa_carry=1 -> res_out=0x01. Then usa_acc=1 XOR B=0x01 -> 0x00.
- Backpressure: hold res_ready_in=0 for 5 cycles -> res_valid_out, res_out, flags_out stable and cmd_ready_out=0 throughout. Release -> cmd_ready_out=1 the following cycle.
- CLR after nonzero acc -> res_valid_out at T+1, res_out=0, acc_out=0, carry_reg cleared; the next usa_carry ADD 0x00+0x00 gives 0x00.
- Assert rst_n_in at the 4th MUL cycle -> all outputs 0 asynchronously, no res_valid_out. After release, cmd_ready_out=1 and a new ADD completes normally.
